mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Parameters
REQ-001 DATA_W, 32, data and address width in bits.
REQ-002 DEPTH, 256, data-memory size in 32-bit words; power of two; ADDR_W = log2(DEPTH).

Interface
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mem_to_reg_in, reg_write_in  in  1 each  WB controls from EX/MEM.
REQ-006 mem_read_in, mem_write_in, beq_instruction_in  in  1 each  MEM controls from EX/MEM.
REQ-007 alu_result_in  in  32  ALU result; byte address for loads and stores.
REQ-008 write_data_in  in  32  store data, i.e. the forwarded rs2 value.
REQ-009 reg_rd_in  in  5  destination register.
REQ-010 flag_beq_in  in  1  ALU equality flag.
REQ-011 branch_taken  out  1  combinational beq_instruction_in AND flag_beq_in, driven to the fetch/flush logic.
REQ-012 ex_mem_reg_rd, ex_mem_reg_write, alu_ex_mem  out  5/1/32  combinational copies of reg_rd_in, reg_write_in and alu_result_in, driven to EX forwarding.
REQ-013 mem_wb_reg_rd, mem_wb_reg_write, alu_data_mem_wb  out  5/1/32  WB-side forwarding source: MEM/WB rd, MEM/WB reg_write, and the selected write-back value.
REQ-014 mem_to_reg_out, reg_write_out  out  1 each  registered WB controls.
REQ-015 read_data_out, alu_result_out  out  32 each  registered load data and registered ALU result.
REQ-016 reg_rd_out  out  5  registered destination register.

Function
REQ-017 Data memory SHALL be DEPTH x 32, word-addressed by alu_result_in[ADDR_W+1:2].
- Address bits [1:0] are ignored.
- Bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH*4.
REQ-018 Write: when mem_write_in=1, the rising edge SHALL write write_data_in to the addressed word; no other word changes.
REQ-019 Read: when mem_read_in=1, the addressed word SHALL be read combinationally and captured into read_data_out on the same edge, giving a load latency of one cycle to the MEM/WB output.
REQ-020 When mem_read_in=0, read_data_out SHALL capture 0.
REQ-021 Simultaneous read and write to the same word SHALL return the old contents (read-before-write); the new value is stored.
REQ-022 The MEM/WB register SHALL capture mem_to_reg_in, reg_write_in, alu_result_in and reg_rd_in every rising edge. There is no stall or enable.
REQ-023 alu_data_mem_wb SHALL equal read_data_out when mem_to_reg_out=1, else alu_result_out.
REQ-024 mem_wb_reg_rd SHALL equal reg_rd_out, and mem_wb_reg_write SHALL equal reg_write_out.
REQ-025 branch_taken SHALL be purely combinational and SHALL NOT be registered here.
REQ-026 When reg_rd_in=0, the signals pass through unchanged; x0 suppression is done by the consumers.

Reset
REQ-027 While reset=0, all MEM/WB outputs SHALL be 0 immediately, without waiting for a clock edge: mem_to_reg_out, reg_write_out, read_data_out, alu_result_out, reg_rd_out.
REQ-028 While reset=0, writes SHALL be inhibited.
REQ-029 Data-memory contents SHALL NOT be cleared by reset and SHALL be retained across it.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight MEM/WB contents.
- On the first edge after reset releases, the register captures the current inputs.

Verification
REQ-031 Store then load: cycle 1 mem_write_in=1, alu_result_in=0x10, write_data_in=0xDEADBEEF; cycle 2 mem_read_in=1, alu_result_in=0x10, mem_to_reg_in=1, reg_rd_in=5 -> after the edge read_data_out=0xDEADBEEF, alu_data_mem_wb=0xDEADBEEF, reg_rd_out=5.
REQ-032 Wrap and alignment: store 0x1234 at address 0x13 -> a load at 0x10 and a load at 0x410 (DEPTH=256) both return 0x1234.
REQ-033 Read-before-write: word 0x20 holds 0xA; drive read and write together with data 0xB -> read_data_out=0xA, and a following load returns 0xB.
REQ-034 ALU path: mem_to_reg_in=0, reg_write_in=1, alu_result_in=0x55, reg_rd_in=7 -> next cycle alu_data_mem_wb=0x55, mem_wb_reg_write=1, mem_wb_reg_rd=7, read_data_out=0.
REQ-035 Branch: beq_instruction_in=1 with flag_beq_in toggling 0 then 1 -> branch_taken follows 0 then 1 in the same cycle; with beq_instruction_in=0 and flag_beq_in=1 -> branch_taken=0.
REQ-036 Reset mid-operation:
- Assert reset=0 asynchronously between edges -> all MEM/WB outputs read 0 at once.
- A store presented during reset is not written.
- Previously stored words still read back correctly after reset releases.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline MEM stage. Word-addressed data memory with
//                combinational read and read-before-write behaviour,
//                MEM/WB pipeline register, branch resolution and forwarding
//                taps for the EX and WB sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   // WB controls from EX/MEM
   input  logic              mem_to_reg_in,
   input  logic              reg_write_in,
   // MEM controls from EX/MEM
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              beq_instruction_in,
   // datapath from EX/MEM
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] write_data_in,
   input  logic [4:0]        reg_rd_in,
   input  logic              flag_beq_in,
   // branch resolution to fetch/flush logic
   output logic              branch_taken,
   // EX-side forwarding taps (EX/MEM contents)
   output logic [4:0]        ex_mem_reg_rd,
   output logic              ex_mem_reg_write,
   output logic [DATA_W-1:0] alu_ex_mem,
   // WB-side forwarding taps (MEM/WB contents)
   output logic [4:0]        mem_wb_reg_rd,
   output logic              mem_wb_reg_write,
   output logic [DATA_W-1:0] alu_data_mem_wb,
   // MEM/WB register outputs
   output logic              mem_to_reg_out,
   output logic              reg_write_out,
   output logic [DATA_W-1:0] read_data_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [4:0]        reg_rd_out
);

   localparam int ADDR_W = $clog2(DEPTH);

   // Data memory; deliberately has no reset so contents survive rst_n
   logic [DATA_W-1:0] r_mem [DEPTH];

   // MEM/WB pipeline register
   logic              r_mem_to_reg;
   logic              r_reg_write;
   logic [DATA_W-1:0] r_read_data;
   logic [DATA_W-1:0] r_alu_result;
   logic [4:0]        r_reg_rd;

   // Byte address -> word index; low two bits and bits above the array drop out
   logic [ADDR_W-1:0] w_word_addr;
   logic [DATA_W-1:0] w_rd_word;

   // Address decode and asynchronous read of the current contents
   always_comb begin
      w_word_addr = alu_result_in[ADDR_W+1:2];
      w_rd_word   = r_mem[w_word_addr];
   end

   // Memory write; blocked while reset is held so a store in flight is lost
   always_ff @(posedge clk) begin
      if (rst_n && mem_write_in) begin
         r_mem[w_word_addr] <= write_data_in;
      end
   end

   // MEM/WB register; read data is the pre-write word, zero when not loading
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_read_data  <= '0;
         r_alu_result <= '0;
         r_reg_rd     <= 5'd0;
      end else begin
         r_mem_to_reg <= mem_to_reg_in;
         r_reg_write  <= reg_write_in;
         r_read_data  <= mem_read_in ? w_rd_word : '0;
         r_alu_result <= alu_result_in;
         r_reg_rd     <= reg_rd_in;
      end
   end

   // Combinational branch decision and forwarding/write-back taps
   always_comb begin
      branch_taken     = beq_instruction_in & flag_beq_in;
      ex_mem_reg_rd    = reg_rd_in;
      ex_mem_reg_write = reg_write_in;
      alu_ex_mem       = alu_result_in;
      mem_to_reg_out   = r_mem_to_reg;
      reg_write_out    = r_reg_write;
      read_data_out    = r_read_data;
      alu_result_out   = r_alu_result;
      reg_rd_out       = r_reg_rd;
      mem_wb_reg_rd    = r_reg_rd;
      mem_wb_reg_write = r_reg_write;
      alu_data_mem_wb  = r_mem_to_reg ? r_read_data : r_alu_result;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed vector table,
//                reset sequence, and randomized traffic against a word-array
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_to_reg_in = 1'b0, reg_write_in = 1'b0;
   logic        mem_read_in = 1'b0, mem_write_in = 1'b0, beq_instruction_in = 1'b0;
   logic [31:0] alu_result_in = '0, write_data_in = '0;
   logic [4:0]  reg_rd_in = '0;
   logic        flag_beq_in = 1'b0;
   logic        branch_taken;
   logic [4:0]  ex_mem_reg_rd, mem_wb_reg_rd, reg_rd_out;
   logic        ex_mem_reg_write, mem_wb_reg_write, mem_to_reg_out, reg_write_out;
   logic [31:0] alu_ex_mem, alu_data_mem_wb, read_data_out, alu_result_out;

   int n_pass  = 0;
   int n_total = 0;

   mem_stage #(.DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .beq_instruction_in(beq_instruction_in),
      .alu_result_in(alu_result_in), .write_data_in(write_data_in),
      .reg_rd_in(reg_rd_in), .flag_beq_in(flag_beq_in),
      .branch_taken(branch_taken),
      .ex_mem_reg_rd(ex_mem_reg_rd), .ex_mem_reg_write(ex_mem_reg_write),
      .alu_ex_mem(alu_ex_mem),
      .mem_wb_reg_rd(mem_wb_reg_rd), .mem_wb_reg_write(mem_wb_reg_write),
      .alu_data_mem_wb(alu_data_mem_wb),
      .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
      .read_data_out(read_data_out), .alu_result_out(alu_result_out),
      .reg_rd_out(reg_rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr, rd, m2r, regw, beq, flag;
      logic [31:0] addr, wdata;
      logic [4:0]  rdst;
      logic        exp_branch;
      logic [31:0] exp_rdata, exp_alu, exp_wb;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic wr, input logic rd, input logic m2r, input logic regw,
                        input logic beq, input logic flag, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rdst);
      mem_write_in = wr; mem_read_in = rd; mem_to_reg_in = m2r; reg_write_in = regw;
      beq_instruction_in = beq; flag_beq_in = flag; alu_result_in = addr;
      write_data_in = wdata; reg_rd_in = rdst;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_m2r"},   {31'd0, mem_to_reg_out}, 32'd0);
      chk({tag, "_regw"},  {31'd0, reg_write_out}, 32'd0);
      chk({tag, "_rdata"}, read_data_out, 32'd0);
      chk({tag, "_alu"},   alu_result_out, 32'd0);
      chk({tag, "_rd"},    {27'd0, reg_rd_out}, 32'd0);
      chk({tag, "_wb"},    alu_data_mem_wb, 32'd0);
      chk({tag, "_wbrd"},  {27'd0, mem_wb_reg_rd}, 32'd0);
      chk({tag, "_wbrw"},  {31'd0, mem_wb_reg_write}, 32'd0);
   endtask

   task automatic add(input logic wr, input logic rd, input logic m2r, input logic regw,
                      input logic beq, input logic flag, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rdst,
                      input logic eb, input logic [31:0] er, input logic [31:0] ea,
                      input logic [31:0] ew);
      vec_t v;
      v.wr = wr; v.rd = rd; v.m2r = m2r; v.regw = regw; v.beq = beq; v.flag = flag;
      v.addr = addr; v.wdata = wdata; v.rdst = rdst;
      v.exp_branch = eb; v.exp_rdata = er; v.exp_alu = ea; v.exp_wb = ew;
      vecs.push_back(v);
   endtask

   logic [31:0] model [DEPTH];

   initial begin
      //      wr rd m2r rw beq fl addr          wdata          rd  br rdata         alu           wb
      add(1, 0, 0, 0, 0, 0, 32'h10,  32'hDEADBEEF, 5'd0, 0, 32'h0,        32'h10,  32'h10);
      add(0, 1, 1, 1, 0, 0, 32'h10,  32'h0,        5'd5, 0, 32'hDEADBEEF, 32'h10,  32'hDEADBEEF);
      add(1, 0, 0, 0, 0, 0, 32'h13,  32'h1234,     5'd0, 0, 32'h0,        32'h13,  32'h13);
      add(0, 1, 1, 1, 0, 0, 32'h10,  32'h0,        5'd3, 0, 32'h1234,     32'h10,  32'h1234);
      add(0, 1, 1, 1, 0, 0, 32'h410, 32'h0,        5'd3, 0, 32'h1234,     32'h410, 32'h1234);
      add(1, 0, 0, 0, 0, 0, 32'h20,  32'hA,        5'd0, 0, 32'h0,        32'h20,  32'h20);
      add(1, 1, 1, 1, 0, 0, 32'h20,  32'hB,        5'd2, 0, 32'hA,        32'h20,  32'hA);
      add(0, 1, 1, 1, 0, 0, 32'h20,  32'h0,        5'd2, 0, 32'hB,        32'h20,  32'hB);
      add(0, 0, 0, 1, 0, 0, 32'h55,  32'h0,        5'd7, 0, 32'h0,        32'h55,  32'h55);
      add(0, 1, 0, 1, 0, 0, 32'h20,  32'h0,        5'd0, 0, 32'hB,        32'h20,  32'h20);
      add(0, 0, 0, 0, 1, 0, 32'h0,   32'h0,        5'd1, 0, 32'h0,        32'h0,   32'h0);
      add(0, 0, 0, 0, 1, 1, 32'h4,   32'h0,        5'd1, 1, 32'h0,        32'h4,   32'h4);
      add(0, 0, 0, 0, 0, 1, 32'h8,   32'h0,        5'd1, 0, 32'h0,        32'h8,   32'h8);

      // power-on reset, asserted between edges
      #1 rst_n = 1'b0;
      #1 chk_all_zero("por");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // directed table
      foreach (vecs[i]) begin
         drive(vecs[i].wr, vecs[i].rd, vecs[i].m2r, vecs[i].regw, vecs[i].beq,
               vecs[i].flag, vecs[i].addr, vecs[i].wdata, vecs[i].rdst);
         #2;
         chk($sformatf("v%0d_branch", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_branch});
         chk($sformatf("v%0d_exalu", i), alu_ex_mem, vecs[i].addr);
         @(posedge clk); #1;
         chk($sformatf("v%0d_rdata", i), read_data_out, vecs[i].exp_rdata);
         chk($sformatf("v%0d_alu", i), alu_result_out, vecs[i].exp_alu);
         chk($sformatf("v%0d_wb", i), alu_data_mem_wb, vecs[i].exp_wb);
         chk($sformatf("v%0d_rd", i), {27'd0, mem_wb_reg_rd}, {27'd0, vecs[i].rdst});
         chk($sformatf("v%0d_regw", i), {31'd0, mem_wb_reg_write}, {31'd0, vecs[i].regw});
      end

      // reset in the middle of operation
      drive(0, 0, 0, 1, 0, 0, 32'h77, 32'h0, 5'd9);
      @(posedge clk); #1;
      chk("pre_rst_regw", {31'd0, reg_write_out}, 32'd1);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("mid_rst");
      drive(1, 0, 0, 1, 0, 0, 32'h10, 32'hFFFFFFFF, 5'd6);
      repeat (2) @(posedge clk);
      #1 chk_all_zero("held_rst");
      rst_n = 1'b1;
      drive(0, 1, 1, 1, 0, 0, 32'h10, 32'h0, 5'd4);
      @(posedge clk); #1;
      chk("post_rst_rdata", read_data_out, 32'h1234);
      chk("post_rst_wb", alu_data_mem_wb, 32'h1234);
      chk("post_rst_rd", {27'd0, reg_rd_out}, 32'd4);
      drive(0, 1, 1, 1, 0, 0, 32'h20, 32'h0, 5'd4);
      @(posedge clk); #1;
      chk("post_rst_rdata2", read_data_out, 32'hB);

      // fill every word so the model knows the full contents
      for (int w = 0; w < DEPTH; w++) begin
         model[w] = $urandom;
         drive(1, 0, 0, 0, 0, 0, 32'(w * 4), model[w], 5'd0);
         @(posedge clk); #1;
      end

      // randomized traffic against the word-array model
      for (int n = 0; n < 300; n++) begin
         logic        wr, rd, m2r, regw, beq, flag;
         logic [31:0] addr, wdata, exp_rdata;
         logic [4:0]  rdst;
         int          widx;
         wr = 1'($urandom); rd = 1'($urandom); m2r = 1'($urandom); regw = 1'($urandom);
         beq = 1'($urandom); flag = 1'($urandom);
         addr = $urandom; wdata = $urandom; rdst = 5'($urandom);
         drive(wr, rd, m2r, regw, beq, flag, addr, wdata, rdst);
         widx = int'((addr / 4) % DEPTH);
         exp_rdata = rd ? model[widx] : 32'd0;
         if (wr) model[widx] = wdata;
         #2;
         chk($sformatf("r%0d_branch", n), {31'd0, branch_taken}, {31'd0, beq && flag});
         chk($sformatf("r%0d_exrd", n), {27'd0, ex_mem_reg_rd}, {27'd0, rdst});
         chk($sformatf("r%0d_exrw", n), {31'd0, ex_mem_reg_write}, {31'd0, regw});
         @(posedge clk); #1;
         chk($sformatf("r%0d_rdata", n), read_data_out, exp_rdata);
         chk($sformatf("r%0d_alu", n), alu_result_out, addr);
         chk($sformatf("r%0d_wb", n), alu_data_mem_wb, m2r ? exp_rdata : addr);
         chk($sformatf("r%0d_rd", n), {27'd0, reg_rd_out}, {27'd0, rdst});
         chk($sformatf("r%0d_m2r", n), {31'd0, mem_to_reg_out}, {31'd0, m2r});
         chk($sformatf("r%0d_regw", n), {31'd0, mem_wb_reg_write}, {31'd0, regw});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
